seqgen_serial_tx: RTL
=====================

Name: seqgen_serial_tx

Overview:
Serial bit-sequence transmitter. It loads a parallel pattern, a length and a repeat count, then shifts the bits out one per clock, LSB first, with a valid qualifier. It is the stimulus side for the serial sequence detectors in this test area: its x_out drives a detector's serial input x. An optional built-in tracker counts "101" occurrences in the emitted stream so that benches can cross-check the detector's y pulses.

Parameters:
MAX_LEN, 16, maximum pattern length in bits; width of load_pattern
LEN_W, 5, width of load_len; must hold MAX_LEN
CNT_W, 8, width of load_repeat and hit_cnt

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
load_valid  input  1  load request
load_ready  output  1  high only in IDLE
load_pattern  input  MAX_LEN  pattern; bit 0 is sent first
load_len  input  LEN_W  number of bits per repetition
load_repeat  input  CNT_W  number of repetitions
x_out  output  1  serial data; 0 whenever x_valid=0
x_valid  output  1  x_out carries a pattern bit this cycle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the last bit
hit_cnt  output  CNT_W  "101" count (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, bit counter and repeat counter cleared.
  - Outputs: x_out=0, x_valid=0, busy=0, done=0, hit_cnt=0, load_ready=1.
  - Reset mid-transfer aborts the transfer at once; no done pulse is issued.
- States:
  - IDLE: load_ready=1. On load_valid && load_ready at edge k, latch pattern, effective length and effective repeat; go to SHIFT. If the effective length is 0, go straight to DONE instead.
  - SHIFT: x_valid=1, x_out = current bit. Advance one bit per clock. At the end of each repetition, reload the latched pattern and continue with no gap cycle. After bit len*repeat, go to DONE.
  - DONE: one cycle with done=1, x_valid=0, load_ready=0. Then return to IDLE.
- Latency:
  - First bit is visible in the cycle after the accepting edge, i.e. cycle k+1.
  - Bits occupy cycles k+1 .. k+len*repeat, continuously.
  - done=1 in cycle k+len*repeat+1.
- Input conditioning:
  - load_len > MAX_LEN is clamped to MAX_LEN.
  - load_repeat=0 is treated as 1.
  - Pattern bits at or above the effective length are ignored.
- load_valid outside IDLE is ignored: no queuing, no corruption of the transfer in progress.
- All outputs are registered, or decoded from state only; none depends combinationally on the load_* inputs.

Optional Feature:
Macro: SEQGEN_HIT_CNT_EN

Defined:
- A tracker FSM (T0..T3) advances only in cycles with x_valid=1, on the x_out value:
  - T0: 1→T1, 0→T0
  - T1: 0→T2, 1→T0
  - T2: 1→T3, 0→T0
  - T3: 1→T1, 0→T0
- Each entry into T3 increments hit_cnt, which saturates at 2^CNT_W-1.
- Tracker state and hit_cnt are cleared on an accepted load. hit_cnt holds its value through DONE and IDLE.
- This transition set is mandatory because it mirrors the detector's overlap rule exactly.

Not defined:
- hit_cnt is tied to 0 and no tracker logic exists; the port list is unchanged.

Test Plan:
1. Load pattern=0b101, len=3, repeat=1 at edge 0 → x_out/x_valid = 1/1, 0/1, 1/1 in cycles 1-3; done=1 in cycle 4; hit_cnt=1 (macro on); load_ready=1 again in cycle 5.
2. Load pattern=0b01101, len=5, repeat=2 → stream 1,0,1,1,0,1,0,1,1,0 in cycles 1-10, no gap between repetitions; done in cycle 11; hit_cnt=2.
3. Load len=0, repeat=3 → x_valid stays 0; done=1 in cycle 1; busy=1 for cycle 1 only.
4. Load len=20 with MAX_LEN=16, repeat=0 → exactly 16 bits sent, i.e. clamped length with repeat treated as 1; done in cycle 17.
5. During SHIFT of a len=8 transfer, assert load_valid with a different pattern → ignored (load_ready=0); the original 8 bits are sent unchanged.
6. Assert rst low after bit 2 of a len=8 transfer → x_valid, busy and hit_cnt drop to 0 immediately; no done pulse; after release, load_ready=1 and a new load is accepted.

Source files
------------

// File: rtl/seqgen_serial_tx.sv
// rtl/seqgen_serial_tx.sv - serial bit-sequence transmitter, LSB first, with valid qualifier
// Optional "101" hit tracker enabled by defining SEQGEN_HIT_CNT_EN.
module seqgen_serial_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] load_pattern,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [CNT_W-1:0]   load_repeat,
    output logic               x_out,
    output logic               x_valid,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]         state;
    logic [MAX_LEN-1:0] shreg;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   rep_cnt;

    logic               accept;
    logic [LEN_W-1:0]   len_eff;
    logic [CNT_W-1:0]   rep_eff;

    always_comb begin
        accept  = load_valid && (state == S_IDLE);
        len_eff = (load_len > LEN_MAX) ? LEN_MAX : load_len;
        rep_eff = (load_repeat == '0) ? CNT_ONE : load_repeat;
    end

    // bit_cnt and rep_cnt count what remains after the current bit/repetition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        pat_q   <= load_pattern;
                        shreg   <= load_pattern;
                        len_q   <= len_eff;
                        rep_cnt <= rep_eff - CNT_ONE;
                        if (len_eff == '0) begin
                            bit_cnt <= '0;
                            state   <= S_DONE;
                        end else begin
                            bit_cnt <= len_eff - LEN_ONE;
                            state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == '0) begin
                        if (rep_cnt == '0) begin
                            shreg <= '0;
                            state <= S_DONE;
                        end else begin
                            shreg   <= pat_q;
                            bit_cnt <= len_q - LEN_ONE;
                            rep_cnt <= rep_cnt - CNT_ONE;
                        end
                    end else begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt - LEN_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        load_ready = (state == S_IDLE);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        x_valid    = (state == S_SHIFT);
        x_out      = (state == S_SHIFT) && shreg[0];
    end

`ifdef SEQGEN_HIT_CNT_EN
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    logic [1:0]       trk;
    logic [1:0]       trk_next;
    logic [CNT_W-1:0] hit_q;

    // A 1 seen in T1 returns to T0, matching the detector's overlap rule
    always_comb begin
        trk_next = T0;
        case (trk)
            T0: trk_next = x_out ? T1 : T0;
            T1: trk_next = x_out ? T0 : T2;
            T2: trk_next = x_out ? T3 : T0;
            T3: trk_next = x_out ? T1 : T0;
            default: trk_next = T0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk   <= T0;
            hit_q <= '0;
        end else if (accept) begin
            trk   <= T0;
            hit_q <= '0;
        end else if (x_valid) begin
            trk <= trk_next;
            if ((trk_next == T3) && (hit_q != '1)) begin
                hit_q <= hit_q + CNT_ONE;
            end
        end
    end

    assign hit_cnt = hit_q;
`else
    assign hit_cnt = '0;
`endif

endmodule
